// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM generator: channel codes, FSM state
// encodings, default timing parameters, widths and the duty clamp helper.
// ---------------------------------------------------------------------------
package pwm_pkg;

   // Widths: the period counter must hold values up to PERIODO (<= 21 bits),
   // the incoming duty word is 19 bits of which only the low 18 are used.
   localparam int CNT_W  = 21;
   localparam int PWM_W  = 19;
   localparam int DUTY_W = 18;

   // Default timing at 100 MHz: 20 ms period, 0.5 ms .. 2.5 ms servo pulse.
   localparam int unsigned PERIODO_DEF   = 2_000_000;
   localparam int unsigned SERVO_MIN_DEF = 50_000;
   localparam int unsigned SERVO_MAX_DEF = 250_000;

   // Channel codes as presented on BOTON_SEL.
   typedef enum logic [1:0] {
      SEL_NINGUNO = 2'b00,
      SEL_MR      = 2'b01,
      SEL_LED     = 2'b10,
      SEL_MDC     = 2'b11
   } sel_e;

   // FSM states; the encoding is visible on the ESTADO debug port.
   typedef enum logic [1:0] {
      APAGADO = 2'b00,
      ACTIVO  = 2'b01,
      CAMBIO  = 2'b10
   } estado_e;

   // Clamp a raw duty to the legal range of the target channel. The servo
   // is held inside its pulse window; the other channels saturate at a full
   // period, which yields a constant-high output.
   function automatic logic [CNT_W-1:0] clamp_duty(
      input sel_e              sel,
      input logic [DUTY_W-1:0] d,
      input logic [CNT_W-1:0]  periodo,
      input logic [CNT_W-1:0]  servo_min,
      input logic [CNT_W-1:0]  servo_max
   );
      logic [CNT_W-1:0] dx;
      logic [CNT_W-1:0] r;
      dx = {{(CNT_W-DUTY_W){1'b0}}, d};
      if (sel == SEL_MR) begin
         if (dx < servo_min)      r = servo_min;
         else if (dx > servo_max) r = servo_max;
         else                     r = dx;
      end else begin
         r = (dx > periodo) ? periodo : dx;
      end
      return r;
   endfunction

endpackage

// File: rtl/pwm_generador_if.sv
// ---------------------------------------------------------------------------
// pwm_generador_if
// Command bus from the control block to the PWM generator.
//   PWM        requested high time in clock cycles (bit 18 unused)
//   BOTON_SEL  channel code (see sel_e in pwm_pkg)
// Modports: master drives the command, slave (the generator) consumes it.
// ---------------------------------------------------------------------------
interface pwm_generador_if;
   import pwm_pkg::*;

   logic [PWM_W-1:0] PWM;
   logic [1:0]       BOTON_SEL;

   modport master (output PWM, output BOTON_SEL);
   modport slave  (input  PWM, input  BOTON_SEL);

endinterface

// File: rtl/pwm_contador.sv
// ---------------------------------------------------------------------------
// pwm_contador
// Free-running period counter 0 .. PERIODO-1 with a registered end-of-period
// strobe.
//   clk_i  clock
//   rst_i  synchronous, active-high reset
//   cnt_o  current count (21 bits)
//   fin_o  high exactly while cnt_o == PERIODO-1
// ---------------------------------------------------------------------------
module pwm_contador
   import pwm_pkg::*;
#(
   parameter int unsigned PERIODO = PERIODO_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             fin_o
);

   localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(PERIODO - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fin_q, fin_d;

   // The strobe is derived from the next count so that, once registered, it
   // lines up with the cycle in which the counter shows its last value.
   always_comb begin
      cnt_d = (cnt_q == ULTIMO) ? '0 : cnt_q + CNT_W'(1);
      fin_d = (cnt_d == ULTIMO);
   end

   // NOTE: reset is synchronous here, so it lives inside the clocked branch
   // rather than in the sensitivity list.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         fin_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register update based on
         // the values from before the edge, independent of statement order.
         cnt_q <= cnt_d;
         fin_q <= fin_d;
      end
   end

   assign cnt_o = cnt_q;
   assign fin_o = fin_q;

endmodule

// File: rtl/pwm_generador.sv
// ---------------------------------------------------------------------------
// pwm_generador
// Drives one of three actuator PWM outputs (servo, DC motor, LED) from a
// duty word and channel code sampled once per period. Switching between two
// active channels inserts one full dead period with all outputs low.
//   CLK          clock
//   RST          synchronous, active-high reset
//   ctrl         command bus (PWM duty, BOTON_SEL channel), slave modport
//   SAL_MR       servo pulse output
//   SAL_MDC      DC motor PWM output
//   SAL_LED      LED PWM output
//   FIN_PERIODO  one-cycle strobe on the last cycle of each period
//   ESTADO       current FSM state (debug)
// ---------------------------------------------------------------------------
module pwm_generador
   import pwm_pkg::*;
#(
   parameter int unsigned PERIODO   = PERIODO_DEF,
   parameter int unsigned SERVO_MIN = SERVO_MIN_DEF,
   parameter int unsigned SERVO_MAX = SERVO_MAX_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   pwm_generador_if.slave   ctrl,
   output logic             SAL_MR,
   output logic             SAL_MDC,
   output logic             SAL_LED,
   output logic             FIN_PERIODO,
   output logic [1:0]       ESTADO
);

   localparam logic [CNT_W-1:0] P_PER  = CNT_W'(PERIODO);
   localparam logic [CNT_W-1:0] P_SMIN = CNT_W'(SERVO_MIN);
   localparam logic [CNT_W-1:0] P_SMAX = CNT_W'(SERVO_MAX);

   // ------------------------------------------------------------------
   // Period counter
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] cnt;
   logic             fin;

   pwm_contador #(
      .PERIODO (PERIODO)
   ) u_contador (
      .clk_i (CLK),
      .rst_i (RST),
      .cnt_o (cnt),
      .fin_o (fin)
   );

   // ------------------------------------------------------------------
   // Command decode
   // ------------------------------------------------------------------
   sel_e              req;
   logic [CNT_W-1:0]  duty_nuevo;
   logic              unused_pwm_msb;

   assign req            = sel_e'(ctrl.BOTON_SEL);
   assign unused_pwm_msb = ctrl.PWM[PWM_W-1];
   // The clamp follows the requested channel; a new duty is only ever loaded
   // when that request becomes (or stays) the active channel.
   assign duty_nuevo = clamp_duty(req, ctrl.PWM[DUTY_W-1:0], P_PER, P_SMIN, P_SMAX);

   // ------------------------------------------------------------------
   // FSM and output compare
   // ------------------------------------------------------------------
   estado_e          estado_q,  estado_d;
   sel_e             sel_act_q, sel_act_d;
   sel_e             sel_pend_q, sel_pend_d;
   logic [CNT_W-1:0] duty_q,    duty_d;
   logic             mr_q,  mr_d;
   logic             mdc_q, mdc_d;
   logic             led_q, led_d;
   logic             en_alto;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // leaves one unassigned and no latch can be inferred.
      estado_d   = estado_q;
      sel_act_d  = sel_act_q;
      sel_pend_d = sel_pend_q;
      duty_d     = duty_q;

      // `fin` marks the last cycle of the period, so everything below takes
      // effect on the edge that wraps the counter: the running pulse is never
      // cut short or stretched.
      if (fin) begin
         unique case (estado_q)
            APAGADO: begin
               if (req != SEL_NINGUNO) begin
                  estado_d  = ACTIVO;
                  sel_act_d = req;
                  duty_d    = duty_nuevo;
               end
            end
            ACTIVO: begin
               if (req == sel_act_q) begin
                  duty_d = duty_nuevo;
               end else if (req == SEL_NINGUNO) begin
                  estado_d = APAGADO;
               end else begin
                  estado_d   = CAMBIO;
                  sel_pend_d = req;
               end
            end
            CAMBIO: begin
               if (req == sel_pend_q) begin
                  estado_d  = ACTIVO;
                  sel_act_d = sel_pend_q;
                  duty_d    = duty_nuevo;
               end else if (req == SEL_NINGUNO) begin
                  estado_d = APAGADO;
               end else begin
                  // A different channel during dead time restarts the dead period.
                  sel_pend_d = req;
               end
            end
            default: estado_d = APAGADO;
         endcase
      end

      // Outputs use the current state and duty; only the selected channel can
      // be high, so at most one output is ever asserted.
      en_alto = (estado_q == ACTIVO) && (cnt < duty_q);
      mr_d    = en_alto && (sel_act_q == SEL_MR);
      mdc_d   = en_alto && (sel_act_q == SEL_MDC);
      led_d   = en_alto && (sel_act_q == SEL_LED);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         estado_q   <= APAGADO;
         sel_act_q  <= SEL_NINGUNO;
         sel_pend_q <= SEL_NINGUNO;
         duty_q     <= '0;
         mr_q       <= 1'b0;
         mdc_q      <= 1'b0;
         led_q      <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         sel_act_q  <= sel_act_d;
         sel_pend_q <= sel_pend_d;
         duty_q     <= duty_d;
         mr_q       <= mr_d;
         mdc_q      <= mdc_d;
         led_q      <= led_d;
      end
   end

   assign SAL_MR      = mr_q;
   assign SAL_MDC     = mdc_q;
   assign SAL_LED     = led_q;
   assign FIN_PERIODO = fin;
   assign ESTADO      = estado_q;

endmodule

// File: tb/tb_pwm_generador.sv
// ---------------------------------------------------------------------------
// tb_pwm_generador
// Self-checking bench for pwm_generador with a 1000-cycle period. Each table
// vector is driven mid-period and its expected result (high-cycle counts per
// channel and state for the following period) is queued; each measured
// period pops one expectation and compares it.
// ---------------------------------------------------------------------------
module tb_pwm_generador;

   localparam int PER  = 1000;
   localparam int SMIN = 50;
   localparam int SMAX = 250;

   typedef struct {
      logic [1:0]  sel;
      logic [18:0] pwm;
      int          mr;
      int          mdc;
      int          led;
      logic [1:0]  estado;
   } vec_t;

   typedef struct {
      int         mr;
      int         mdc;
      int         led;
      logic [1:0] estado;
   } exp_t;

   typedef struct {
      int         mr;
      int         mdc;
      int         led;
      int         multi;
      int         fin_cnt;
      int         fin_pos;
      logic [1:0] estado;
   } res_t;

   logic       clk;
   logic       rst;
   logic       sal_mr, sal_mdc, sal_led, fin_periodo;
   logic [1:0] estado;

   int checks   = 0;
   int failures = 0;

   vec_t vecs[$];
   exp_t exp_q[$];

   pwm_generador_if bus ();

   pwm_generador #(
      .PERIODO   (PER),
      .SERVO_MIN (SMIN),
      .SERVO_MAX (SMAX)
   ) dut (
      .CLK         (clk),
      .RST         (rst),
      .ctrl        (bus),
      .SAL_MR      (sal_mr),
      .SAL_MDC     (sal_mdc),
      .SAL_LED     (sal_led),
      .FIN_PERIODO (fin_periodo),
      .ESTADO      (estado)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] sel, input logic [18:0] pwm,
                      input int mr, input int mdc, input int led,
                      input logic [1:0] est);
      vec_t v;
      v.sel = sel; v.pwm = pwm; v.mr = mr; v.mdc = mdc; v.led = led; v.estado = est;
      vecs.push_back(v);
   endtask

   // Samples one output period: the cycles with counter values 1..PER-1 and
   // then 0, which carry exactly one period's compare results. Optionally
   // drives a new command at counter value 500 and queues its expectation.
   task automatic measure(input bit drive, input vec_t v, output res_t r);
      exp_t e;
      r.mr = 0; r.mdc = 0; r.led = 0; r.multi = 0;
      r.fin_cnt = 0; r.fin_pos = -1; r.estado = 2'b11;
      for (int j = 0; j < PER; j++) begin
         @(negedge clk);
         if (sal_mr)  r.mr++;
         if (sal_mdc) r.mdc++;
         if (sal_led) r.led++;
         if (int'(sal_mr) + int'(sal_mdc) + int'(sal_led) > 1) r.multi++;
         if (fin_periodo) begin
            r.fin_cnt++;
            r.fin_pos = j;
         end
         if (j == 0) r.estado = estado;
         if (drive && j == 499) begin
            bus.BOTON_SEL = v.sel;
            bus.PWM       = v.pwm;
            e.mr = v.mr; e.mdc = v.mdc; e.led = v.led; e.estado = v.estado;
            exp_q.push_back(e);
         end
      end
   endtask

   initial begin
      res_t r;
      exp_t e;
      vec_t v;
      exp_t e0;
      bit   drv;
      int   nv;
      int   fin_idx;
      int   hi_cnt;

      // Each vector is applied mid-period; expected values describe the NEXT period.
      add(2'b11, 19'd300,  0, 300,    0, 2'b01); // off -> MDC 300
      add(2'b11, 19'd300,  0, 300,    0, 2'b01); // hold
      add(2'b11, 19'd700,  0, 700,    0, 2'b01); // change mid-period; current keeps 300
      add(2'b10, 19'd0,    0,   0,    0, 2'b10); // MDC -> LED: dead period
      add(2'b10, 19'd0,    0,   0,    0, 2'b01); // LED active, duty 0
      add(2'b10, 19'd1500, 0,   0, 1000, 2'b01); // LED saturates at full period
      add(2'b00, 19'd0,    0,   0,    0, 2'b00); // off
      add(2'b01, 19'd10,  50,   0,    0, 2'b01); // MR clamped to min
      add(2'b01, 19'd400, 250,  0,    0, 2'b01); // MR clamped to max
      add(2'b01, 19'd250, 250,  0,    0, 2'b01); // MR exactly max
      add(2'b11, 19'd500,  0,   0,    0, 2'b10); // MR -> MDC: dead
      add(2'b10, 19'd123,  0,   0,    0, 2'b10); // pending changes: dead restarts
      add(2'b10, 19'd123,  0,   0,  123, 2'b01); // LED active
      add(2'b11, 19'd5,    0,   0,    0, 2'b10); // LED -> MDC: dead
      add(2'b00, 19'd5,    0,   0,    0, 2'b00); // dead -> off
      add(2'b11, 19'd1000, 0, 1000,   0, 2'b01); // duty == period: constant high
      add(2'b11, 19'h4012C, 0, 300,   0, 2'b01); // bit 18 ignored -> 300
      add(2'b11, 19'd999,  0, 999,    0, 2'b01); // one short of full
      add(2'b01, 19'd49,   0,   0,    0, 2'b10); // MDC -> MR: dead
      add(2'b01, 19'd49,  50,   0,    0, 2'b01); // MR just below min
      add(2'b01, 19'd51,  51,   0,    0, 2'b01); // MR just above min
      add(2'b11, 19'd300,  0,   0,    0, 2'b10); // MR -> MDC: dead
      add(2'b11, 19'd300,  0, 300,    0, 2'b01); // MDC 300
      nv = vecs.size();

      // Reset with a request already present on the bus.
      rst = 1'b1;
      bus.PWM = 19'd300;
      bus.BOTON_SEL = 2'b11;
      repeat (3) @(negedge clk);
      check("rst_sal_mr",  int'(sal_mr),      0);
      check("rst_sal_mdc", int'(sal_mdc),     0);
      check("rst_sal_led", int'(sal_led),     0);
      check("rst_fin",     int'(fin_periodo), 0);
      check("rst_estado",  int'(estado),      0);

      // First period after reset is always idle.
      e0.mr = 0; e0.mdc = 0; e0.led = 0; e0.estado = 2'b00;
      exp_q.push_back(e0);
      rst = 1'b0;

      for (int p = 0; p <= nv; p++) begin
         drv = (p < nv);
         if (drv) v = vecs[p];
         else     v = vecs[0];
         measure(drv, v, r);
         check($sformatf("p%0d_sb_depth", p), exp_q.size(), drv ? 2 : 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("p%0d_mr", p),      r.mr,          e.mr);
            check($sformatf("p%0d_mdc", p),     r.mdc,         e.mdc);
            check($sformatf("p%0d_led", p),     r.led,         e.led);
            check($sformatf("p%0d_estado", p),  int'(r.estado), int'(e.estado));
         end
         check($sformatf("p%0d_fin_cnt", p), r.fin_cnt, 1);
         check($sformatf("p%0d_fin_pos", p), r.fin_pos, PER - 2);
         check($sformatf("p%0d_onehot", p),  r.multi,   0);
      end

      // MDC 300 is active now; go to counter value 100, inside the pulse.
      repeat (100) @(negedge clk);
      check("pre_rst_mdc", int'(sal_mdc), 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_mdc",    int'(sal_mdc),     0);
      check("mid_rst_mr",     int'(sal_mr),      0);
      check("mid_rst_led",    int'(sal_led),     0);
      check("mid_rst_fin",    int'(fin_periodo), 0);
      check("mid_rst_estado", int'(estado),      0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Counter restarts from 0: the strobe is PER-1 cycles later, idle period.
      fin_idx = -1;
      hi_cnt  = 0;
      for (int j = 0; j < PER + 100; j++) begin
         @(negedge clk);
         if (sal_mr || sal_mdc || sal_led) hi_cnt++;
         if (fin_periodo) begin
            fin_idx = j;
            break;
         end
      end
      check("post_rst_fin_idx", fin_idx, PER - 2);
      check("post_rst_idle",    hi_cnt,  0);

      // Next period resumes MDC 300 from the held request.
      @(negedge clk);
      measure(1'b0, vecs[0], r);
      check("post_rst_mdc",    r.mdc,          300);
      check("post_rst_mr",     r.mr,           0);
      check("post_rst_led",    r.led,          0);
      check("post_rst_estado", int'(r.estado), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
